// File: rtl/reg_bank_pkg.sv
// Constants shared by the register bank and its write-side front end.
package reg_bank_pkg;

  localparam int AW       = 5;
  localparam int DW       = 32;
  localparam int NREGS    = 32;
  localparam int ZERO_REG = 0;

endpackage

// File: rtl/reg_wr_fifo.sv
// In-order FIFO of pending register writes; exposes every slot with its
// valid flag and age (distance from head) so the top can build forwarding.
module reg_wr_fifo #(
  parameter  int DEPTH = 4,
  parameter  int AW    = 5,
  parameter  int DW    = 32,
  localparam int PW    = $clog2(DEPTH),
  localparam int CW    = PW + 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            push,
  input  logic            pop,
  input  logic [AW-1:0]   push_addr,
  input  logic [DW-1:0]   push_data,
  output logic [AW-1:0]   head_addr,
  output logic [DW-1:0]   head_data,
  output logic [CW-1:0]   count,
  output logic            empty,
  output logic            full,
  output logic [AW-1:0]   ent_addr [DEPTH],
  output logic [DW-1:0]   ent_data [DEPTH],
  output logic [DEPTH-1:0] ent_valid,
  output logic [PW-1:0]   ent_age  [DEPTH]
);

  logic [AW-1:0] mem_addr [DEPTH];
  logic [DW-1:0] mem_data [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [CW-1:0] cnt;
  logic          do_push;
  logic          do_pop;

  // Full is judged before the edge: a pop on the same edge does not free a slot.
  assign do_push = push && (cnt != CW'(DEPTH));
  assign do_pop  = pop  && (cnt != '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({do_push, do_pop})
        2'b10:   cnt <= cnt + CW'(1);
        2'b01:   cnt <= cnt - CW'(1);
        default: cnt <= cnt;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && do_push) begin
      mem_addr[wr_ptr] <= push_addr;
      mem_data[wr_ptr] <= push_data;
    end
  end

  assign head_addr = mem_addr[rd_ptr];
  assign head_data = mem_data[rd_ptr];
  assign count     = cnt;
  assign empty     = (cnt == '0);
  assign full      = (cnt == CW'(DEPTH));

  for (genvar i = 0; i < DEPTH; i++) begin : g_ent
    assign ent_age[i]   = PW'(i) - rd_ptr;
    assign ent_valid[i] = ({1'b0, ent_age[i]} < cnt);
    assign ent_addr[i]  = mem_addr[i];
    assign ent_data[i]  = mem_data[i];
  end

endmodule

// File: rtl/reg_write_buffer.sv
// Write buffer in front of the register bank: filters r0 writes, queues the
// rest, retires one per cycle through a register stage, and forwards queued data.
module reg_write_buffer #(
  parameter  int DEPTH = 4,
  parameter  int AW    = reg_bank_pkg::AW,
  parameter  int DW    = reg_bank_pkg::DW,
  localparam int CW    = $clog2(DEPTH) + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req_valid,
  output logic          req_ready,
  input  logic [AW-1:0] req_addr,
  input  logic [DW-1:0] req_data,
  input  logic          drain_en,
  output logic          regWrite,
  output logic [AW-1:0] WriteReg,
  output logic [DW-1:0] writeData,
  input  logic [AW-1:0] LookupReg1,
  input  logic [AW-1:0] LookupReg2,
  output logic          Hit1,
  output logic          Hit2,
  output logic [DW-1:0] HitData1,
  output logic [DW-1:0] HitData2,
  output logic [CW-1:0] count,
  output logic          empty,
  output logic          full
);
  import reg_bank_pkg::*;

  localparam int PW = $clog2(DEPTH);

  logic          accept;
  logic          push;
  logic          pop;
  logic [AW-1:0] head_addr;
  logic [DW-1:0] head_data;
  logic [AW-1:0] ent_addr [DEPTH];
  logic [DW-1:0] ent_data [DEPTH];
  logic [DEPTH-1:0] ent_valid;
  logic [PW-1:0] ent_age  [DEPTH];

  assign req_ready = !full && !rst;
  assign accept    = req_valid && req_ready;
  // r0 requests complete the handshake but are dropped here.
  assign push      = accept && (req_addr != AW'(ZERO_REG));
  assign pop       = drain_en && !empty;

  reg_wr_fifo #(
    .DEPTH (DEPTH),
    .AW    (AW),
    .DW    (DW)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .pop       (pop),
    .push_addr (req_addr),
    .push_data (req_data),
    .head_addr (head_addr),
    .head_data (head_data),
    .count     (count),
    .empty     (empty),
    .full      (full),
    .ent_addr  (ent_addr),
    .ent_data  (ent_data),
    .ent_valid (ent_valid),
    .ent_age   (ent_age)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      regWrite  <= 1'b0;
      WriteReg  <= '0;
      writeData <= '0;
    end else begin
      regWrite <= pop;
      if (pop) begin
        WriteReg  <= head_addr;
        writeData <= head_data;
      end
    end
  end

  logic [AW-1:0] lk_addr [2];
  logic [1:0]    lk_hit;
  logic [DW-1:0] lk_data [2];

  assign lk_addr[0] = LookupReg1;
  assign lk_addr[1] = LookupReg2;

  // Youngest match wins: the entry with the largest age among hits.
  for (genvar p = 0; p < 2; p++) begin : g_lookup
    logic          hit;
    logic [DW-1:0] data;
    logic [PW-1:0] best_age;

    always_comb begin
      hit      = 1'b0;
      data     = '0;
      best_age = '0;
      for (int i = 0; i < DEPTH; i++) begin
        if (ent_valid[i] && (lk_addr[p] != AW'(ZERO_REG)) &&
            (ent_addr[i] == lk_addr[p]) && (!hit || (ent_age[i] > best_age))) begin
          hit      = 1'b1;
          data     = ent_data[i];
          best_age = ent_age[i];
        end
      end
    end

    assign lk_hit[p]  = hit;
    assign lk_data[p] = data;
  end

  assign Hit1     = lk_hit[0];
  assign Hit2     = lk_hit[1];
  assign HitData1 = lk_data[0];
  assign HitData2 = lk_data[1];

endmodule

// File: tb/tb_reg_write_buffer.sv
// Bench for reg_write_buffer: directed scenarios plus random traffic, all
// outputs compared every cycle against a queue-based model of the buffer.
module tb_reg_write_buffer;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic [4:0]  req_addr;
  logic [31:0] req_data;
  logic        drain_en;
  logic        regWrite;
  logic [4:0]  WriteReg;
  logic [31:0] writeData;
  logic [4:0]  LookupReg1;
  logic [4:0]  LookupReg2;
  logic        Hit1;
  logic        Hit2;
  logic [31:0] HitData1;
  logic [31:0] HitData2;
  logic [2:0]  count;
  logic        empty;
  logic        full;

  always #5 clk = ~clk;

  reg_write_buffer #(.DEPTH(DEPTH)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_addr   (req_addr),
    .req_data   (req_data),
    .drain_en   (drain_en),
    .regWrite   (regWrite),
    .WriteReg   (WriteReg),
    .writeData  (writeData),
    .LookupReg1 (LookupReg1),
    .LookupReg2 (LookupReg2),
    .Hit1       (Hit1),
    .Hit2       (Hit2),
    .HitData1   (HitData1),
    .HitData2   (HitData2),
    .count      (count),
    .empty      (empty),
    .full       (full)
  );

  typedef struct {
    logic [4:0]  a;
    logic [31:0] d;
  } ent_t;

  ent_t        mq[$];
  logic        m_we = 1'b0;
  logic [4:0]  m_wa = '0;
  logic [31:0] m_wd = '0;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, obs, exp);
    end
  endtask

  function automatic void ref_lookup(input logic [4:0] q, output logic hit, output logic [31:0] data);
    hit  = 1'b0;
    data = '0;
    if (q != 0) begin
      for (int i = mq.size() - 1; i >= 0; i--) begin
        if (mq[i].a == q) begin
          hit  = 1'b1;
          data = mq[i].d;
          break;
        end
      end
    end
  endfunction

  task automatic check_all();
    logic        eh1, eh2;
    logic [31:0] ed1, ed2;
    ref_lookup(LookupReg1, eh1, ed1);
    ref_lookup(LookupReg2, eh2, ed2);
    chk("req_ready", 64'(req_ready), 64'(!rst && (mq.size() < DEPTH)));
    chk("count",     64'(count),     64'(mq.size()));
    chk("empty",     64'(empty),     64'(mq.size() == 0));
    chk("full",      64'(full),      64'(mq.size() == DEPTH));
    chk("regWrite",  64'(regWrite),  64'(m_we));
    chk("WriteReg",  64'(WriteReg),  64'(m_wa));
    chk("writeData", 64'(writeData), 64'(m_wd));
    chk("Hit1",      64'(Hit1),      64'(eh1));
    chk("HitData1",  64'(HitData1),  64'(ed1));
    chk("Hit2",      64'(Hit2),      64'(eh2));
    chk("HitData2",  64'(HitData2),  64'(ed2));
  endtask

  // Rules of one clock edge: reset clears everything; otherwise retire the
  // oldest entry if allowed, and accept a non-r0 request if there was room.
  task automatic model_edge();
    ent_t e;
    bit   room;
    if (rst) begin
      mq.delete();
      m_we = 1'b0;
      m_wa = '0;
      m_wd = '0;
    end else begin
      room = (mq.size() < DEPTH);
      if (drain_en && mq.size() > 0) begin
        e    = mq.pop_front();
        m_we = 1'b1;
        m_wa = e.a;
        m_wd = e.d;
      end else begin
        m_we = 1'b0;
      end
      if (req_valid && room && req_addr != 0) begin
        e.a = req_addr;
        e.d = req_data;
        mq.push_back(e);
      end
    end
  endtask

  task automatic step(input bit do_chk = 1'b1);
    #1;
    if (do_chk) check_all();
    @(posedge clk);
    model_edge();
    @(negedge clk);
  endtask

  task automatic drive(input logic v, input logic [4:0] a, input logic [31:0] d);
    req_valid = v;
    req_addr  = a;
    req_data  = d;
  endtask

  initial begin
    rst = 1'b1; drain_en = 1'b0; LookupReg1 = '0; LookupReg2 = '0;
    drive(1'b0, '0, '0);
    @(negedge clk);
    step(1'b0);
    step();
    rst = 1'b0;

    // single write: strobe two edges after the push, for one cycle
    drain_en = 1'b1;
    drive(1'b1, 5'd3, 32'd100);
    step();
    drive(1'b0, '0, '0);
    #1 chk("single_cnt1", 64'(count), 64'd1);
    chk("single_we0", 64'(regWrite), 64'd0);
    step();
    #1 chk("single_we1", 64'(regWrite), 64'd1);
    chk("single_addr", 64'(WriteReg), 64'd3);
    chk("single_data", 64'(writeData), 64'd100);
    chk("single_cnt0", 64'(count), 64'd0);
    step();
    #1 chk("single_we_drop", 64'(regWrite), 64'd0);

    // fill and stall
    drain_en = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      drive(1'b1, 5'(k), 32'(11 * k));
      step();
    end
    drive(1'b1, 5'd5, 32'd55);
    #1 chk("fill_full", 64'(full), 64'd1);
    chk("fill_ready", 64'(req_ready), 64'd0);
    step();
    drive(1'b0, '0, '0);
    #1 chk("fill_no5th", 64'(count), 64'd4);
    drain_en = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      step();
      #1 chk("drain_we", 64'(regWrite), 64'd1);
      chk("drain_addr", 64'(WriteReg), 64'(k));
      chk("drain_data", 64'(writeData), 64'(11 * k));
    end
    step();
    #1 chk("drain_idle", 64'(regWrite), 64'd0);

    // zero register
    drive(1'b1, 5'd0, 32'd9999);
    LookupReg1 = 5'd0;
    #1 chk("zero_ready", 64'(req_ready), 64'd1);
    step();
    drive(1'b0, '0, '0);
    #1 chk("zero_cnt", 64'(count), 64'd0);
    chk("zero_hit", 64'(Hit1), 64'd0);
    step();
    #1 chk("zero_we", 64'(regWrite), 64'd0);

    // forwarding: youngest of two same-address entries wins
    drain_en = 1'b0;
    drive(1'b1, 5'd10, 32'd250); step();
    drive(1'b1, 5'd10, 32'd777); step();
    drive(1'b0, '0, '0);
    LookupReg1 = 5'd10; LookupReg2 = 5'd31;
    #1 chk("fwd_hit1", 64'(Hit1), 64'd1);
    chk("fwd_data1", 64'(HitData1), 64'd777);
    chk("fwd_hit2", 64'(Hit2), 64'd0);
    chk("fwd_data2", 64'(HitData2), 64'd0);

    // push/pop while full, pointers wrapping
    drive(1'b1, 5'd20, 32'd2); step();
    drive(1'b1, 5'd21, 32'd3); step();
    drain_en = 1'b1;
    for (int k = 0; k < 8; k++) begin
      drive(1'b1, 5'(22 + k), 32'(1000 + k));
      step();
      #1 chk("wrap_cnt_le4", 64'(count <= 3'd4), 64'd1);
    end
    drive(1'b0, '0, '0);
    for (int k = 0; k < 6; k++) step();

    // reset with entries queued
    drain_en = 1'b0;
    for (int k = 0; k < 3; k++) begin
      drive(1'b1, 5'(5 + k), 32'(500 + k));
      step();
    end
    drive(1'b0, '0, '0);
    rst = 1'b1;
    step();
    rst = 1'b0; drain_en = 1'b1;
    #1 chk("rst_cnt", 64'(count), 64'd0);
    chk("rst_we", 64'(regWrite), 64'd0);
    step();
    #1 chk("rst_no_retire", 64'(regWrite), 64'd0);
    step();

    // random traffic
    for (int n = 0; n < 3000; n++) begin
      rst        = ($urandom_range(0, 99) == 0);
      drain_en   = ($urandom_range(0, 3) != 0);
      LookupReg1 = 5'($urandom_range(0, 7));
      LookupReg2 = 5'($urandom_range(0, 31));
      drive(1'($urandom_range(0, 2) != 0),
            ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 7)),
            $urandom());
      step();
    end
    rst = 1'b0;
    drive(1'b0, '0, '0);
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/reg_write_buffer.md
# reg_write_buffer

Write-side front end for the 32×32 register bank: accepts register-write requests over a valid/ready handshake, buffers them in a small in-order FIFO, and retires at most one per cycle onto the bank's `regWrite`/`WriteReg`/`writeData` port. Sits between the writeback stage and `RegisterBank`. It also provides two forwarding lookups so decode can see values still queued and not yet written.

## Interface
- `DEPTH`, 4: FIFO entries; power of two, ≥2
- `AW`, 5: register address width
- `DW`, 32: data width

- `clk`  in  1  rising-edge clock
- `rst`  in  1  synchronous, active-high reset
- `req_valid`  in  1  write request present
- `req_ready`  out  1  buffer can accept; equals `!full && !rst`
- `req_addr`  in  AW  destination register
- `req_data`  in  DW  value to write
- `drain_en`  in  1  permits retiring one entry per cycle
- `regWrite`  out  1  registered write strobe to bank
- `WriteReg`  out  AW  registered write address to bank
- `writeData`  out  DW  registered write data to bank
- `LookupReg1`, `LookupReg2`  in  AW  forwarding query addresses
- `Hit1`, `Hit2`  out  1  query matches a queued entry
- `HitData1`, `HitData2`  out  DW  data of youngest matching entry, 0 if no hit
- `count`  out  $clog2(DEPTH)+1  entries queued
- `empty`, `full`  out  1  FIFO status

## Operation
- Accept: on an edge with `req_valid && req_ready`.
- `req_addr != 0`: enqueue {addr, data} at the tail.
- `req_addr == 0`: handshake completes but nothing is enqueued; register 0 is never written.
- Retire: on each edge with `drain_en && !empty`:
  - Load the head entry into `WriteReg`/`writeData`.
  - Set `regWrite <= 1` and pop.
- Otherwise `regWrite <= 0`. `WriteReg`/`writeData` hold their last values.
- Simultaneous push and pop on the same edge: both occur, `count` unchanged. Push is still gated by `full` as sampled before the edge, so no push when full, even with a pop on that edge.
- Order: strict FIFO. Two queued writes to the same register retire oldest first.
- Lookup: purely combinational over valid FIFO entries only.
  - The output register stage is excluded, since the bank sees it directly.
  - Lookup address 0 never hits.
  - On multiple matches, the youngest entry (nearest tail) wins.
- Pointers: `$clog2(DEPTH)` bits, wrapping modulo `DEPTH`. `full = (count == DEPTH)`, `empty = (count == 0)`.

## Timing
- Reset values:
  - `regWrite`, `WriteReg`, `writeData`, `count` = 0
  - `empty` = 1, `full` = 0, `req_ready` = 0 while `rst` is high
  - pointers = 0, `Hit*` = 0, `HitData*` = 0
- Reset mid-operation: all queued entries are discarded and nothing retires. Reset wins over a simultaneous push or pop.
- Latency with an empty buffer and `drain_en = 1`:
  - request accepted at edge N → entry visible to lookup after edge N
  - `regWrite` high for one cycle after edge N+1
- Throughput: one retire per cycle. A continuous stream at `count = 1` sustains a full rate.
- `drain_en` low: entries accumulate. `req_ready` drops in the cycle after `count` reaches `DEPTH`.
- `Hit*`/`HitData*` follow lookup inputs and FIFO contents combinationally within the same cycle. A popped entry stops hitting in the cycle its `regWrite` is asserted.

## Structure
- Shared package `reg_bank_pkg`: `AW`, `DW`, `NREGS = 32`, `ZERO_REG = 0`. `RegisterBank` uses it too.
- Sub-module `reg_wr_fifo`:
  - synchronous FIFO with push/pop/count/full/empty
  - exposes the entry arrays plus per-entry valid and age vectors for lookup
- Top level contains the zero-register filter, output register stage, and the two lookup priority muxes.

## Test plan
- Reset then single write: push (3, 100) with `drain_en = 1` → `regWrite = 1`, `WriteReg = 3`, `writeData = 100` for exactly one cycle, two edges after the push; `count` returns to 0.
- Fill and stall: `drain_en = 0`, push (1,11), (2,22), (3,33), (4,44) → `full = 1`, `req_ready = 0`; a fifth push of (5,55) is not accepted. Then `drain_en = 1` → writes to 1, 2, 3, 4 on consecutive cycles, in order.
- Zero register: push (0, 9999) → handshake completes, `count` stays 0, no `regWrite`; `LookupReg1 = 0` gives `Hit1 = 0`.
- Forwarding: `drain_en = 0`, push (10,250) then (10,777) → `LookupReg1 = 10` gives `Hit1 = 1`, `HitData1 = 777`; `LookupReg2 = 31` gives `Hit2 = 0`, `HitData2 = 0`.
- Simultaneous push/pop at full with wrap: with 4 queued and `drain_en = 1`, hold `req_valid` high for 8 cycles → `count` never exceeds 4, no entry is lost or duplicated, and pointers wrap correctly.
- Mid-operation reset: 3 queued, assert `rst` for one cycle → `count = 0`, `regWrite = 0` next cycle, no further writes retire.
